// File: rtl/mux_select_if.sv
// Bus bundle for the N-way word mux: flattened slots, select and enable in;
// combinational and registered results out.
interface mux_select_if #(
    parameter int WIDTH = 3,
    parameter int NUM   = 8
);
    localparam int SEL_W = (NUM < 2) ? 1 : $clog2(NUM);

    logic [NUM*WIDTH-1:0] in;
    logic [SEL_W-1:0]     select;
    logic                 en;
    logic [WIDTH-1:0]     out;
    logic                 sel_err;
    logic [WIDTH-1:0]     out_q;
    logic                 sel_err_q;

    modport master (
        output in, select, en,
        input  out, sel_err, out_q, sel_err_q
    );

    modport slave (
        input  in, select, en,
        output out, sel_err, out_q, sel_err_q
    );
endinterface

// File: rtl/mux_select.sv
// Parameterized N-way word multiplexer; slot 0 sits in the MSBs of the bus.
// Provides a combinational result plus an enable-loaded registered copy.
module mux_select #(
    parameter int WIDTH = 3,
    parameter int NUM   = 8
) (
    input logic        clk,
    input logic        reset,
    mux_select_if.slave bus
);
    localparam int SEL_W = (NUM < 2) ? 1 : $clog2(NUM);

    if (NUM < 2) begin : g_bad_num
        $error("mux_select: NUM must be >= 2");
    end
    if (WIDTH < 1) begin : g_bad_width
        $error("mux_select: WIDTH must be >= 1");
    end

    logic [NUM-1:0][WIDTH-1:0] slots;
    logic [WIDTH-1:0]          mux_out;
    logic                      err;
    logic [WIDTH-1:0]          out_r;
    logic                      err_r;

    for (genvar k = 0; k < NUM; k++) begin : g_slot
        assign slots[k] = bus.in[(NUM-1-k)*WIDTH +: WIDTH];
    end

    // Out-of-range selects (non power-of-2 NUM) fall through to zero with err set.
    always_comb begin
        mux_out = '0;
        err     = 1'b1;
        for (int k = 0; k < NUM; k++) begin
            if (bus.select == SEL_W'(k)) begin
                mux_out = slots[k];
                err     = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_r <= '0;
            err_r <= 1'b0;
        end else if (bus.en) begin
            out_r <= mux_out;
            err_r <= err;
        end
    end

    assign bus.out       = mux_out;
    assign bus.sel_err   = err;
    assign bus.out_q     = out_r;
    assign bus.sel_err_q = err_r;
endmodule

// File: tb/tb_mux_select.sv
// Randomized and directed bench for mux_select at NUM=8, 2 and 3 (WIDTH=3),
// checked against a shift-and-mask slot model with a one-edge register model.
module tb_mux_select;
    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [31:0] eq  [3];
    logic [31:0] eeq [3];

    always #5 clk = ~clk;

    mux_select_if #(.WIDTH(3), .NUM(8)) if8 ();
    mux_select_if #(.WIDTH(3), .NUM(2)) if2 ();
    mux_select_if #(.WIDTH(3), .NUM(3)) if3 ();

    mux_select #(.WIDTH(3), .NUM(8)) u8 (.clk(clk), .reset(reset), .bus(if8.slave));
    mux_select #(.WIDTH(3), .NUM(2)) u2 (.clk(clk), .reset(reset), .bus(if2.slave));
    mux_select #(.WIDTH(3), .NUM(3)) u3 (.clk(clk), .reset(reset), .bus(if3.slave));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_slot(input logic [63:0] b, input int num, input int sel);
        if (sel >= num) return 32'd0;
        return 32'((b >> ((num - 1 - sel) * 3)) & 64'h7);
    endfunction

    function automatic logic [31:0] ref_err(input int num, input int sel);
        return (sel >= num) ? 32'd1 : 32'd0;
    endfunction

    task automatic check_q(input string tag);
        chk({tag, "_q8"},  32'(if8.out_q),     eq[0]);
        chk({tag, "_eq8"}, 32'(if8.sel_err_q), eeq[0]);
        chk({tag, "_q2"},  32'(if2.out_q),     eq[1]);
        chk({tag, "_eq2"}, 32'(if2.sel_err_q), eeq[1]);
        chk({tag, "_q3"},  32'(if3.out_q),     eq[2]);
        chk({tag, "_eq3"}, 32'(if3.sel_err_q), eeq[2]);
    endtask

    task automatic step(input string tag,
                        input logic [23:0] i8, input logic [2:0] s8,
                        input logic [5:0]  i2, input logic       s2,
                        input logic [8:0]  i3, input logic [1:0] s3,
                        input logic e);
        @(negedge clk);
        if8.in = i8; if8.select = s8; if8.en = e;
        if2.in = i2; if2.select = s2; if2.en = e;
        if3.in = i3; if3.select = s3; if3.en = e;
        #1;
        chk({tag, "_o8"}, 32'(if8.out),     ref_slot(64'(i8), 8, int'(s8)));
        chk({tag, "_e8"}, 32'(if8.sel_err), ref_err(8, int'(s8)));
        chk({tag, "_o2"}, 32'(if2.out),     ref_slot(64'(i2), 2, int'(s2)));
        chk({tag, "_e2"}, 32'(if2.sel_err), ref_err(2, int'(s2)));
        chk({tag, "_o3"}, 32'(if3.out),     ref_slot(64'(i3), 3, int'(s3)));
        chk({tag, "_e3"}, 32'(if3.sel_err), ref_err(3, int'(s3)));
        @(posedge clk);
        if (e && reset) begin
            eq[0] = ref_slot(64'(i8), 8, int'(s8)); eeq[0] = ref_err(8, int'(s8));
            eq[1] = ref_slot(64'(i2), 2, int'(s2)); eeq[1] = ref_err(2, int'(s2));
            eq[2] = ref_slot(64'(i3), 3, int'(s3)); eeq[2] = ref_err(3, int'(s3));
        end
        #1;
        check_q(tag);
    endtask

    localparam logic [23:0] IN8 = {3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd1, 3'd2, 3'd3};
    localparam logic [5:0]  IN2 = {3'd0, 3'd1};
    localparam logic [8:0]  IN3 = {3'd0, 3'd1, 3'd2};

    initial begin
        for (int i = 0; i < 3; i++) begin eq[i] = '0; eeq[i] = '0; end
        reset = 1'b0;
        if8.in = '0; if8.select = '0; if8.en = 1'b0;
        if2.in = '0; if2.select = '0; if2.en = 1'b0;
        if3.in = '0; if3.select = '0; if3.en = 1'b0;
        #3;
        check_q("rst");
        @(negedge clk);
        reset = 1'b1;

        // Fixed select=3 held across 11 cycles; NUM=3 sits on its last legal slot.
        for (int c = 0; c < 11; c++)
            step("hold", IN8, 3'd3, IN2, 1'b1, IN3, 2'd2, 1'b1);

        step("n2s0", IN8, 3'd3, IN2, 1'b0, IN3, 2'd3, 1'b1);
        step("n2s1", IN8, 3'd3, IN2, 1'b1, IN3, 2'd3, 1'b1);

        for (int s = 0; s < 8; s++)
            step("sweep", IN8, 3'(s), IN2, 1'(s), IN3, 2'(s), 1'b1);

        // Output register must hold while select keeps moving with en low.
        for (int s = 0; s < 3; s++)
            step("hold_en", IN8, 3'(s + 1), IN2, 1'(s), IN3, 2'(s + 1), 1'b0);

        step("load", IN8, 3'd3, IN2, 1'b1, IN3, 2'd3, 1'b1);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin eq[i] = '0; eeq[i] = '0; end
        check_q("async_rst");
        @(negedge clk);
        reset = 1'b1;
        step("reload", IN8, 3'd3, IN2, 1'b1, IN3, 2'd3, 1'b1);

        for (int r = 0; r < 60; r++)
            step("rand", 24'($urandom), 3'($urandom), 6'($urandom), 1'($urandom),
                 9'($urandom), 2'($urandom), ($urandom_range(0, 3) != 0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
